mpsoc_wb_burst_master: RTL and testbench
========================================

Name: mpsoc_wb_burst_master

Overview:
- Wishbone B3 burst master sitting directly upstream of the single-port RAM slave.
- Takes a block-transfer request (base address, word count, direction) and issues it as a sequence of linear incrementing bursts (CTI 010 / 111).
- Write data streams in through a valid/ready port; read data streams out as a valid-qualified port.
- Used by DMA/boot-load paths to fill or drain on-chip SRAM.

Parameters:
- AW, 32, Wishbone byte-address width.
- DW, 32, data width; only 32 supported (SEL is 4 bits, address step is 4).
- MAX_BURST, 8, maximum beats per Wishbone burst; power of two, 2..16.
- LW, 16, width of the request word-count field.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  transfer request valid.
- req_ready_o  out  1  block idle and able to accept a request.
- req_we_i  in  1  1 = write to memory, 0 = read.
- req_adr_i  in  AW  start byte address, word aligned.
- req_len_i  in  LW  number of words to transfer.
- wr_dat_i  in  DW  write stream data.
- wr_valid_i  in  1  write stream valid.
- wr_ready_o  out  1  write word consumed this cycle.
- rd_dat_o  out  DW  read stream data.
- rd_valid_o  out  1  read word valid this cycle; no backpressure.
- done_o  out  1  one-cycle pulse when the transfer finishes.
- err_o  out  1  one-cycle pulse, coincident with done_o, when aborted by wb_err_i.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  Wishbone write enable.
- wb_bte_o  out  2  burst type extension.
- wb_cti_o  out  3  cycle type identifier.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  bus error.

Behaviour:
- Asynchronous reset drives the block to IDLE and clears all registers.
- While reset is asserted: wb_cyc_o, wb_stb_o, wb_we_o, done_o, err_o, rd_valid_o, wr_ready_o are 0; wb_adr_o = 0, wb_cti_o = 000.
- req_ready_o = (state==IDLE) & !wb_rst_i.
- Fixed outputs: wb_sel_o = 4'hF and wb_bte_o = 00 (linear) at all times.
- States: IDLE, BURST, GAP, FIN.
- IDLE:
  - On req_valid_i & req_ready_o, latch we/adr/len.
  - len=0 -> FIN; otherwise -> BURST at the next edge.
  - First cyc/stb appears the cycle after acceptance.
- BURST entry:
  - beats = min(remaining, MAX_BURST); beat counter loaded.
  - wb_cyc_o = 1; wb_adr_o = current address (registered).
- BURST strobe and data:
  - wb_stb_o = 1 for reads; wb_stb_o = wr_valid_i for writes.
  - While wr_valid_i is low, cyc stays high and stb drops (wait state).
  - wb_dat_o = wr_dat_i (combinational).
- BURST CTI:
  - 010 on every beat except the last beat of the burst, which is 111.
  - A 1-beat burst uses 000 (classic).
- Beat completion: a beat completes on cyc & stb & ack. On completion:
  - address += 4 (AW-bit wrap at the top of the space);
  - remaining -= 1, beat counter -= 1.
  - Write: wr_ready_o = 1 in that cycle.
  - Read: rd_valid_o = 1 and rd_dat_o = wb_dat_i in that cycle (combinational pass-through).
- End of burst:
  - After the last beat of a burst with remaining > 0 -> GAP.
  - GAP holds cyc = 0 for exactly one cycle, then -> BURST for the next burst.
- End of transfer: after the last beat with remaining = 0 -> FIN.
- FIN: cyc = 0, done_o = 1 for one cycle, then -> IDLE.
- Error abort: wb_err_i during an active strobe:
  - beat is not counted; no rd_valid_o/wr_ready_o;
  - cyc/stb drop next edge; -> FIN with err_o = 1;
  - remaining words are discarded.
- Ignored inputs: ack and err while stb = 0 are ignored. Stray wr_valid_i in IDLE is not consumed.
- Request input timing: requests are ignored outside IDLE. req_* inputs need only be held while req_valid_i is high and the request is not yet accepted.

Test Plan:
- Read 3 words @0x10 from RAM preloaded 0xA0,0xA1,0xA2:
  - one burst with adr 0x10/0x14/0x18 and cti 010, 010, 111;
  - rd_valid_o three pulses with those data;
  - done_o pulses the cycle after cyc falls.
- Write 20 words @0x0, MAX_BURST=8, wr_valid_i always 1:
  - bursts of 8, 8, 4, each followed by one idle (GAP) cycle;
  - wr_ready_o = 20 pulses;
  - readback matches.
- Write 4 words with wr_valid_i low for 3 cycles before beat 2:
  - cyc stays 1, stb 0 for those 3 cycles;
  - address holds 0x04;
  - 4 words land at 0x00..0x0C.
- Single word read @0x40:
  - cti 000, one rd_valid_o, done_o.
- req_len_i = 0:
  - no cyc assertion;
  - done_o pulse 1 cycle after acceptance; err_o = 0.
- wb_err_i on 2nd beat of 5-word read:
  - exactly 1 rd_valid_o;
  - cyc low next cycle;
  - done_o and err_o pulse together; req_ready_o = 1 after.
- Async reset asserted mid-burst:
  - cyc/stb go 0 immediately, without waiting for a clock edge;
  - after release, a new request completes normally.

Source files
------------

// File: rtl/mpsoc_wb_burst_master.sv
// Wishbone B3 block-transfer master: splits a request into incrementing bursts of up to MAX_BURST beats.
// First strobe one cycle after acceptance; write beats stall on wr_valid_i, read stream has no backpressure.
module mpsoc_wb_burst_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8,
  parameter int LW        = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [LW-1:0] req_len_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [DW-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP, FIN} state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [LW-1:0] rem_q;
  logic [BW-1:0] beat_q;
  logic          single_q;
  logic          err_q;
  logic          accept, reload, step, abort;

  function automatic logic [BW-1:0] burst_beats(input logic [LW-1:0] n);
    return (n >= LW'(MAX_BURST)) ? BW'(MAX_BURST) : n[BW-1:0];
  endfunction

  assign wb_adr_o = adr_q;
  assign wb_dat_o = wr_dat_i;
  assign rd_dat_o = wb_dat_i;
  assign wb_sel_o = 4'hF;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_cti_o    = 3'b000;
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    accept      = 1'b0;
    reload      = 1'b0;
    step        = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !wb_rst_i;
        if (req_valid_i && !wb_rst_i) begin
          accept  = 1'b1;
          state_d = (req_len_i == '0) ? FIN : BURST;
        end
      end
      BURST: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = we_q;
        wb_stb_o = we_q ? wr_valid_i : 1'b1;
        if (single_q)                wb_cti_o = 3'b000;
        else if (beat_q == BW'(1))   wb_cti_o = 3'b111;
        else                         wb_cti_o = 3'b010;
        // Error takes priority over a simultaneous ack: the beat is dropped.
        if (wb_stb_o && wb_err_i) begin
          abort   = 1'b1;
          state_d = FIN;
        end else if (wb_stb_o && wb_ack_i) begin
          step       = 1'b1;
          wr_ready_o = we_q;
          rd_valid_o = !we_q;
          if (beat_q == BW'(1))
            state_d = (rem_q == LW'(1)) ? FIN : GAP;
        end
      end
      GAP: begin
        reload  = 1'b1;
        state_d = BURST;
      end
      FIN: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q     <= 1'b0;
      adr_q    <= '0;
      rem_q    <= '0;
      beat_q   <= '0;
      single_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we_i;
      adr_q    <= req_adr_i;
      rem_q    <= req_len_i;
      beat_q   <= burst_beats(req_len_i);
      single_q <= (burst_beats(req_len_i) == BW'(1));
      err_q    <= 1'b0;
    end else if (reload) begin
      beat_q   <= burst_beats(rem_q);
      single_q <= (burst_beats(rem_q) == BW'(1));
    end else if (step) begin
      adr_q  <= adr_q + AW'(4);
      rem_q  <= rem_q - LW'(1);
      beat_q <= beat_q - BW'(1);
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpsoc_wb_burst_master.sv
// Randomized bench for mpsoc_wb_burst_master: RAM slave model, transfer-level reference model and scoreboard.
module tb_mpsoc_wb_burst_master;
  localparam int AW = 32, DW = 32, MAXB = 8, LW = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [AW-1:0] req_adr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [DW-1:0] wr_dat_i = '0, rd_dat_o, wb_dat_o, wb_dat_i = '0;
  logic          wr_valid_i = 1'b0, wr_ready_o, rd_valid_o, done_o, err_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  always #5 wb_clk_i = ~wb_clk_i;

  mpsoc_wb_burst_master #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .LW(LW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_len_i(req_len_i),
    .wr_dat_i(wr_dat_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  typedef struct { logic [31:0] adr; logic [2:0] cti; logic we; logic [31:0] dat; logic is_err; } beat_t;
  typedef struct { logic err; logic had_beats; } done_t;

  beat_t       exp_q[$];
  done_t       done_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] slv_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  int n_cmp = 0, n_bad = 0;
  int ack_pct = 100, wr_pct = 100, err_at = -1, beat_cnt = 0;
  int hold_at = -1, hold_n = 0, wait_cnt = 0, done_cnt = 0, done_lat = 0;
  int cyc_n = 0, acc_cyc = 0;
  bit mon_on = 1'b0, ack_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  // RAM slave: ack follows cyc (even with stb low, which the master must ignore).
  always @* begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_cyc_o) begin
      if (err_at >= 0 && beat_cnt == err_at && wb_stb_o) wb_err_i = 1'b1;
      else                                               wb_ack_i = ack_en;
    end
  end

  always @(posedge wb_clk_i) begin
    cyc_n <= cyc_n + 1;
    if (wb_rst_i || done_o) beat_cnt <= 0;
    else if (wb_cyc_o && wb_stb_o && wb_ack_i) beat_cnt <= beat_cnt + 1;
    if (!wb_rst_i && wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) slv_mem[wb_adr_o[31:2]] = wb_dat_o;
    if (!wb_rst_i && wr_ready_o && wr_q.size() > 0) void'(wr_q.pop_front());
  end

  always @(negedge wb_clk_i) begin
    ack_en     = ($urandom_range(0, 99) < ack_pct);
    wr_valid_i = (wr_q.size() > 0) && ($urandom_range(0, 99) < wr_pct);
    wr_dat_i   = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
    if (hold_n > 0 && wb_cyc_o && beat_cnt == hold_at) begin
      wr_valid_i = 1'b0;
      hold_n--;
    end
    wb_dat_i = slv_rd(wb_adr_o);
  end

  // Monitor / scoreboard
  beat_t mb;
  done_t md;
  bit    prev_cyc = 1'b0, after_done = 1'b0;
  int    gap_st = 0;
  logic  exp_wr, exp_rd;
  always @(negedge wb_clk_i) begin
    #2;
    if (!mon_on || wb_rst_i) begin
      prev_cyc = 1'b0; gap_st = 0; after_done = 1'b0;
    end else begin
      if (gap_st == 2) begin chk("gap_cyc_low", wb_cyc_o, 1'b0); gap_st = 1; end
      else if (gap_st == 1) begin chk("gap_one_cycle", wb_cyc_o, 1'b1); gap_st = 0; end
      if (after_done) begin chk("req_ready_after_done", req_ready_o, 1'b1); after_done = 1'b0; end
      exp_wr = wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && wb_we_o;
      exp_rd = wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_we_o;
      if (wr_ready_o || exp_wr) chk("wr_ready", wr_ready_o, exp_wr);
      if (rd_valid_o || exp_rd) chk("rd_valid", rd_valid_o, exp_rd);
      if (wb_cyc_o) begin
        if (wb_stb_o == 1'b0) wait_cnt++;
        if (exp_q.size() == 0) chk("unexpected_cyc", wb_cyc_o, 1'b0);
        else begin
          chk("adr", wb_adr_o, exp_q[0].adr);
          chk("cti", {29'd0, wb_cti_o}, {29'd0, exp_q[0].cti});
          chk("we", wb_we_o, exp_q[0].we);
          if (wb_stb_o && (wb_ack_i || wb_err_i)) begin
            mb = exp_q.pop_front();
            chk("err_on_beat", wb_err_i, mb.is_err);
            if (!mb.is_err && mb.we)  chk("wdat", wb_dat_o, mb.dat);
            if (!mb.is_err && !mb.we) chk("rdat", rd_dat_o, mb.dat);
            if (!mb.is_err && mb.cti != 3'b010 && exp_q.size() > 0) gap_st = 2;
          end
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("unexpected_done", done_o, 1'b0);
        else begin
          md = done_q.pop_front();
          chk("err_o", err_o, md.err);
          chk("cyc_before_done", prev_cyc, md.had_beats);
          chk("cyc_at_done", wb_cyc_o, 1'b0);
          chk("beats_left", exp_q.size(), 0);
          done_lat = cyc_n - acc_cyc;
          done_cnt++;
          after_done = 1'b1;
        end
      end else if (err_o) chk("err_without_done", err_o, 1'b0);
      prev_cyc = wb_cyc_o;
    end
  end

  task automatic issue(input bit we, input logic [31:0] adr, input int len);
    int t = 0;
    @(negedge wb_clk_i);
    req_we_i = we; req_adr_i = adr; req_len_i = LW'(len); req_valid_i = 1'b1;
    while (!req_ready_o && t < 50) begin @(negedge wb_clk_i); t++; end
    if (!req_ready_o) chk("req_ready_timeout", req_ready_o, 1'b1);
    @(posedge wb_clk_i); #1;
    acc_cyc = cyc_n;
    req_valid_i = 1'b0; req_adr_i = $urandom; req_len_i = LW'($urandom); req_we_i = ~we;
  endtask

  task automatic do_xfer(input bit we, input logic [31:0] adr, input int len, input int eat);
    int nb, start, t;
    done_t d;
    nb = (eat >= 0 && eat < len) ? eat + 1 : len;
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      int bi, pos, sz;
      bi = i / MAXB; pos = i % MAXB;
      sz = (len - bi * MAXB < MAXB) ? len - bi * MAXB : MAXB;
      b.adr = adr + 32'(4 * i);
      b.cti = (sz == 1) ? 3'b000 : ((pos == sz - 1) ? 3'b111 : 3'b010);
      b.we = we;
      b.is_err = (i == eat);
      if (we) begin
        b.dat = $urandom;
        wr_q.push_back(b.dat);
        if (!b.is_err) ref_mem[b.adr[31:2]] = b.dat;
      end else b.dat = ref_rd(b.adr);
      exp_q.push_back(b);
    end
    d.err = (eat >= 0 && eat < len);
    d.had_beats = (len > 0);
    done_q.push_back(d);
    err_at = (eat >= 0 && eat < len) ? eat : -1;
    start = done_cnt;
    issue(we, adr, len);
    t = 0;
    while (done_cnt == start && t < 2000) begin @(negedge wb_clk_i); t++; end
    if (done_cnt == start) begin
      chk("done_timeout", 32'(done_cnt), 32'(start + 1));
      exp_q.delete(); done_q.delete();
    end
    @(negedge wb_clk_i);
    wr_q.delete();
    err_at = -1;
    if (we) for (int i = 0; i < nb; i++) chk("mem_readback", slv_rd(adr + 32'(4 * i)), ref_rd(adr + 32'(4 * i)));
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      logic [31:0] v;
      v = $urandom;
      slv_mem[30'(k)] = v; ref_mem[30'(k)] = v;
    end
    for (int k = 0; k < 3; k++) begin
      slv_mem[30'(4 + k)] = 32'hA0 + 32'(k); ref_mem[30'(4 + k)] = 32'hA0 + 32'(k);
    end
    #12;
    chk("rst_cyc", wb_cyc_o, 1'b0);       chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);         chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);          chk("rst_rd_valid", rd_valid_o, 1'b0);
    chk("rst_wr_ready", wr_ready_o, 1'b0); chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_cti", {29'd0, wb_cti_o}, 32'h0); chk("rst_req_ready", req_ready_o, 1'b0);
    chk("sel", {28'd0, wb_sel_o}, 32'hF); chk("bte", {30'd0, wb_bte_o}, 32'h0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0; mon_on = 1'b1;

    do_xfer(1'b0, 32'h10, 3, -1);
    chk("read3_latency", done_lat, 3);
    do_xfer(1'b1, 32'h0, 20, -1);
    do_xfer(1'b0, 32'h0, 20, -1);
    wait_cnt = 0; hold_at = 1; hold_n = 3;
    do_xfer(1'b1, 32'h0, 4, -1);
    chk("wait_states", wait_cnt, 3);
    hold_at = -1;
    do_xfer(1'b0, 32'h40, 1, -1);
    do_xfer(1'b0, 32'h80, 0, -1);
    chk("len0_latency", done_lat, 0);
    ack_pct = 70;
    do_xfer(1'b0, 32'h20, 5, 1);
    do_xfer(1'b0, 32'hFFFF_FFF8, 4, -1);

    // Asynchronous reset in the middle of a stalled burst
    mon_on = 1'b0; ack_pct = 0;
    issue(1'b0, 32'h100, 16);
    @(negedge wb_clk_i); #1;
    chk("cyc_before_reset", wb_cyc_o, 1'b1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("async_rst_cyc", wb_cyc_o, 1'b0);
    chk("async_rst_stb", wb_stb_o, 1'b0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0; ack_pct = 100;
    exp_q.delete(); done_q.delete(); wr_q.delete();
    mon_on = 1'b1;
    do_xfer(1'b0, 32'h10, 3, -1);

    for (int n = 0; n < 30; n++) begin
      int len, eat;
      ack_pct = $urandom_range(40, 100);
      wr_pct  = $urandom_range(30, 100);
      len = $urandom_range(0, 20);
      eat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      do_xfer(1'($urandom_range(0, 1)), {23'd0, 7'($urandom_range(0, 127)), 2'b00}, len, eat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
